// File: rtl/ysyx_25020047_lsu_if.sv
// AXI4-Lite data-memory port between the LSU (master) and the memory interconnect (slave).
interface ysyx_25020047_lsu_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Multi-cycle load/store unit: one EXU request at a time over AXI4-Lite, extended load data to WBU.
// Every output is a register loaded with the value belonging to the next state.
module ysyx_25020047_lsu #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_op,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   ysyx_25020047_lsu_if.master bus,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_memdata,
   output logic                out_err
);

   typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp, StDone} state_e;

   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLh  = 4'd2;
   localparam logic [3:0] OpLw  = 4'd3;
   localparam logic [3:0] OpLbu = 4'd4;
   localparam logic [3:0] OpLhu = 4'd5;
   localparam logic [3:0] OpSb  = 4'd9;
   localparam logic [3:0] OpSh  = 4'd10;
   localparam logic [3:0] OpSw  = 4'd11;

   state_e              state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [1:0]          addr_lo_q, addr_lo_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, memdata_q, memdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic                err_q, err_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                in_ready_q, arvalid_q, rready_q, bready_q, out_valid_q;

   logic                is_load, is_store, misaligned;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [DATA_W-1:0]   load_data;
   logic                aw_ok, w_ok;

   always_comb begin
      is_load    = (in_op == OpLb) || (in_op == OpLh) || (in_op == OpLw) ||
                   (in_op == OpLbu) || (in_op == OpLhu);
      is_store   = (in_op == OpSb) || (in_op == OpSh) || (in_op == OpSw);
      misaligned = (((in_op == OpLh) || (in_op == OpLhu) || (in_op == OpSh)) && in_addr[0]) ||
                   (((in_op == OpLw) || (in_op == OpSw)) && (in_addr[1:0] != 2'b00));
   end

   always_comb begin
      case (addr_lo_q)
         2'd0:    lane_b = bus.rdata[7:0];
         2'd1:    lane_b = bus.rdata[15:8];
         2'd2:    lane_b = bus.rdata[23:16];
         default: lane_b = bus.rdata[31:24];
      endcase
      lane_h = addr_lo_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
      case (op_q)
         OpLb:    load_data = {{24{lane_b[7]}}, lane_b};
         OpLh:    load_data = {{16{lane_h[15]}}, lane_h};
         OpLbu:   load_data = {24'd0, lane_b};
         OpLhu:   load_data = {16'd0, lane_h};
         default: load_data = bus.rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_lo_d = addr_lo_q;
      araddr_d  = araddr_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      memdata_d = memdata_q;
      err_d     = err_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_ok     = !awvalid_q || bus.awready;
      w_ok      = !wvalid_q || bus.wready;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               op_d      = in_op;
               addr_lo_d = in_addr[1:0];
               memdata_d = '0;
               err_d     = 1'b0;
               if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else if (is_load) begin
                  araddr_d = {in_addr[ADDR_W-1:2], 2'b00};
                  state_d  = StRaddr;
               end else if (is_store) begin
                  awaddr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWreq;
                  if (in_op == OpSw) begin
                     wdata_d = in_wdata;
                     wstrb_d = 4'b1111;
                  end else if (in_op == OpSh) begin
                     wdata_d = {2{in_wdata[15:0]}};
                     wstrb_d = 4'b0011 << {in_addr[1], 1'b0};
                  end else begin
                     wdata_d = {4{in_wdata[7:0]}};
                     wstrb_d = 4'b0001 << in_addr[1:0];
                  end
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRaddr: if (bus.arready) state_d = StRdata;
         StRdata: begin
            if (bus.rvalid) begin
               err_d     = (bus.rresp != 2'b00);
               memdata_d = (bus.rresp != 2'b00) ? '0 : load_data;
               state_d   = StDone;
            end
         end
         StWreq: begin
            // Address and data channels may complete in either order.
            if (bus.awready) awvalid_d = 1'b0;
            if (bus.wready)  wvalid_d  = 1'b0;
            if (aw_ok && w_ok) state_d = StWresp;
         end
         StWresp: begin
            if (bus.bvalid) begin
               err_d   = (bus.bresp != 2'b00);
               state_d = StDone;
            end
         end
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         op_q        <= '0;
         addr_lo_q   <= '0;
         araddr_q    <= '0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         memdata_q   <= '0;
         err_q       <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         bready_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_lo_q   <= addr_lo_d;
         araddr_q    <= araddr_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         memdata_q   <= memdata_d;
         err_q       <= err_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         in_ready_q  <= (state_d == StIdle);
         arvalid_q   <= (state_d == StRaddr);
         rready_q    <= (state_d == StRdata);
         bready_q    <= (state_d == StWresp);
         out_valid_q <= (state_d == StDone);
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_memdata = memdata_q;
   assign out_err     = err_q;
   assign bus.araddr  = araddr_q;
   assign bus.arvalid = arvalid_q;
   assign bus.rready  = rready_q;
   assign bus.awaddr  = awaddr_q;
   assign bus.awvalid = awvalid_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;
   assign bus.wvalid  = wvalid_q;
   assign bus.bready  = bready_q;

endmodule
